// File: rtl/peridot_config_layer.sv
// Byte-stream config layer: forwards upstream bytes, decodes escaped bytes and
// config commands, commits a staged config word and returns a status response.
module peridot_config_layer #(
    parameter logic [7:0]              CMD_BYTE       = 8'h3A,
    parameter logic [7:0]              ESC_BYTE       = 8'h3D,
    parameter logic [7:0]              ESC_XOR        = 8'h20,
    parameter int                      CONF_BYTES     = 2,
    parameter logic [8*CONF_BYTES-1:0] CONF_INIT      = (8*CONF_BYTES)'(16'h0039),
    parameter int                      MODE_BIT       = 3,
    parameter int                      TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clock_sig,
    input  logic                      reset_sig,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [7:0]                out_data,
    input  logic                      out_ready,
    input  logic                      pk_valid,
    input  logic [7:0]                pk_data,
    output logic                      pk_ready,
    output logic                      resp_valid,
    output logic [7:0]                resp_data,
    input  logic                      resp_ready,
    output logic [8*CONF_BYTES-1:0]   conf_out,
    input  logic [8*CONF_BYTES-1:0]   conf_in,
    output logic                      conf_update,
    output logic                      abort
);

    localparam int              IW       = $clog2(CONF_BYTES) + 1;
    localparam int              CW       = 8 * CONF_BYTES;
    localparam logic [IW-1:0]   LAST_IDX = IW'(CONF_BYTES - 1);
    localparam logic [31:0]     TO_LIMIT = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ESCAPE, CONFDATA, SENDRESP} state_t;

    state_t          state, state_next;
    logic [IW-1:0]   idx, idx_next;
    logic [31:0]     timer;
    logic [CW-1:0]   staged, staged_next, resp_reg;
    logic [7:0]      resp_byte;
    logic            mode, is_special, in_fire, resp_fire, timeout_hit, commit, timed_state;

    assign mode        = conf_out[MODE_BIT];
    assign is_special  = (in_data == CMD_BYTE) || (in_data == ESC_BYTE);
    assign in_fire     = in_valid && in_ready;
    assign resp_fire   = resp_valid && resp_ready;
    assign timed_state = (state == ESCAPE) || (state == CONFDATA);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && timed_state && (timer == TO_LIMIT);
    assign commit      = (state == CONFDATA) && in_fire && (idx == LAST_IDX);

    // Byte-lane select for staging the incoming payload and reading the response.
    always_comb begin
        staged_next = staged;
        resp_byte   = '0;
        for (int b = 0; b < CONF_BYTES; b++) begin
            if (idx == IW'(b)) begin
                staged_next[8*b +: 8] = in_data;
                resp_byte             = resp_reg[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (in_fire && in_data == CMD_BYTE) begin
                    state_next = CONFDATA;
                    idx_next   = '0;
                end else if (in_fire && in_data == ESC_BYTE) begin
                    state_next = ESCAPE;
                end
            end
            ESCAPE: begin
                if (timeout_hit || in_fire) state_next = IDLE;
            end
            CONFDATA: begin
                if (timeout_hit) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else if (in_fire) begin
                    if (idx == LAST_IDX) begin
                        state_next = SENDRESP;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            SENDRESP: begin
                if (resp_fire) begin
                    if (idx == LAST_IDX) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // A byte arriving on the timeout cycle is left unconsumed so IDLE handles it next.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = in_data;
        pk_ready   = resp_ready;
        resp_valid = pk_valid;
        resp_data  = pk_data;
        case (state)
            IDLE: begin
                if (is_special) begin
                    in_ready = 1'b1;
                end else if (mode) begin
                    out_valid = in_valid;
                    in_ready  = out_ready;
                end else begin
                    in_ready = 1'b1;
                end
            end
            ESCAPE: begin
                out_data = in_data ^ ESC_XOR;
                if (!timeout_hit) begin
                    if (mode) begin
                        out_valid = in_valid;
                        in_ready  = out_ready;
                    end else begin
                        in_ready = 1'b1;
                    end
                end
            end
            CONFDATA: begin
                in_ready   = !timeout_hit;
                pk_ready   = 1'b0;
                resp_valid = 1'b0;
            end
            SENDRESP: begin
                pk_ready   = 1'b0;
                resp_valid = 1'b1;
                resp_data  = resp_byte;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            timer       <= '0;
            staged      <= '0;
            conf_out    <= CONF_INIT;
            resp_reg    <= '0;
            conf_update <= 1'b0;
            abort       <= 1'b0;
        end else begin
            conf_update <= commit;
            abort       <= timeout_hit;
            if (state == CONFDATA && in_fire) staged <= staged_next;
            if (commit) begin
                conf_out <= staged_next;
                resp_reg <= conf_in;
            end
            if (!timed_state || state_next != state || in_fire) timer <= '0;
            else                                                 timer <= timer + 32'd1;
        end
    end

endmodule

// File: tb/tb_peridot_config_layer.sv
// Scoreboard bench for peridot_config_layer: drivers push expected bytes into
// queues, a negedge monitor pops and compares on every output handshake.
module tb_peridot_config_layer;

    logic        clock_sig = 1'b0;
    logic        reset_sig = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        out_valid, out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        pk_valid = 1'b0, pk_ready;
    logic [7:0]  pk_data = 8'h00;
    logic        resp_valid, resp_ready = 1'b1;
    logic [7:0]  resp_data;
    logic [15:0] conf_out;
    logic [15:0] conf_in = 16'h0000;
    logic        conf_update, abort;

    int          err_count = 0, check_count = 0;
    int          out_count = 0, upd_count = 0, abort_count = 0;
    logic [7:0]  out_q[$];
    logic [7:0]  resp_q[$];

    peridot_config_layer #(.TIMEOUT_CYCLES(16)) dut (
        .clock_sig(clock_sig), .reset_sig(reset_sig),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .pk_valid(pk_valid), .pk_data(pk_data), .pk_ready(pk_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
        .conf_out(conf_out), .conf_in(conf_in),
        .conf_update(conf_update), .abort(abort)
    );

    always #5 clock_sig = ~clock_sig;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Present one upstream byte from posedge+1 until accepted, with a cycle bound.
    task automatic apply_stimulus(input logic [7:0] b);
        int n;
        bit fired;
        n = 0;
        fired = 1'b0;
        @(posedge clock_sig);
        #1;
        in_valid = 1'b1;
        in_data  = b;
        while (!fired && n < 50) begin
            @(negedge clock_sig);
            fired = in_ready;
            @(posedge clock_sig);
            n++;
        end
        #1;
        in_valid = 1'b0;
        check_output($sformatf("accept_%h", b), {31'd0, fired}, 32'd1);
    endtask

    task automatic wait_resp_drain(input string name);
        int n;
        n = 0;
        while (resp_q.size() != 0 && n < 50) begin
            @(posedge clock_sig);
            n++;
        end
        #1;
        check_output(name, resp_q.size(), 0);
    endtask

    always @(negedge clock_sig) begin
        if (!reset_sig) begin
            if (out_valid && out_ready) begin
                out_count++;
                if (out_q.size() == 0) begin
                    check_count++;
                    err_count++;
                    $display("[TB] FAIL out_unexpected: got %h, expected none", out_data);
                end else begin
                    check_output("out_byte", {24'd0, out_data}, {24'd0, out_q.pop_front()});
                end
            end
            if (resp_valid && resp_ready) begin
                if (resp_q.size() == 0) begin
                    check_count++;
                    err_count++;
                    $display("[TB] FAIL resp_unexpected: got %h, expected none", resp_data);
                end else begin
                    check_output("resp_byte", {24'd0, resp_data}, {24'd0, resp_q.pop_front()});
                end
            end
            if (conf_update) upd_count++;
            if (abort)       abort_count++;
        end
    end

    initial begin
        int n, bad_valid, bad_data, bad_pk, bad_in, out_before;

        repeat (2) @(posedge clock_sig);
        #1;
        check_output("reset_conf_out", conf_out, 16'h0039);
        check_output("reset_update", conf_update, 0);
        check_output("reset_abort", abort, 0);
        check_output("reset_resp_valid", resp_valid, 0);
        reset_sig = 1'b0;
        #1;
        check_output("idle_in_ready", in_ready, 1);

        // Passthrough with an escaped command byte
        out_q.push_back(8'h41); out_q.push_back(8'h3A); out_q.push_back(8'h42);
        apply_stimulus(8'h41); apply_stimulus(8'h3D); apply_stimulus(8'h1A); apply_stimulus(8'h42);
        @(negedge clock_sig);
        check_output("pass_out_drained", out_q.size(), 0);
        check_output("pass_conf_out", conf_out, 16'h0039);
        check_output("pass_updates", upd_count, 0);

        // Config commit and response, then pk traffic resumes
        conf_in = 16'h1234;
        resp_q.push_back(8'h34); resp_q.push_back(8'h12);
        apply_stimulus(8'h3A); apply_stimulus(8'h30); apply_stimulus(8'hA5);
        wait_resp_drain("cfg_resp_drain");
        check_output("cfg_conf_out", conf_out, 16'hA530);
        check_output("cfg_updates", upd_count, 1);
        @(posedge clock_sig);
        #1;
        pk_valid = 1'b1; pk_data = 8'h77;
        resp_q.push_back(8'h77);
        @(posedge clock_sig);
        #1;
        pk_valid = 1'b0;
        check_output("pk_resumed", resp_q.size(), 0);

        // Mode off: bytes discarded, then forwarding restored
        conf_in = 16'hBEEF;
        resp_q.push_back(8'hEF); resp_q.push_back(8'hBE);
        apply_stimulus(8'h3A); apply_stimulus(8'h00); apply_stimulus(8'h00);
        wait_resp_drain("off_resp_drain");
        check_output("off_conf_out", conf_out, 16'h0000);
        out_before = out_count;
        apply_stimulus(8'h55);
        @(negedge clock_sig);
        check_output("off_no_forward", out_count, out_before);
        conf_in = 16'h00C8;
        resp_q.push_back(8'hC8); resp_q.push_back(8'h00);
        apply_stimulus(8'h3A); apply_stimulus(8'h08); apply_stimulus(8'h00);
        wait_resp_drain("on_resp_drain");
        check_output("on_conf_out", conf_out, 16'h0008);
        out_q.push_back(8'h41);
        apply_stimulus(8'h41);
        @(negedge clock_sig);
        check_output("on_forwarded", out_q.size(), 0);
        check_output("mode_updates", upd_count, 3);

        // Backpressure on the response path, held past the timeout length
        conf_in = 16'h5AC3;
        apply_stimulus(8'h3A); apply_stimulus(8'h09);
        resp_ready = 1'b0;
        apply_stimulus(8'h00);
        pk_valid = 1'b1; pk_data = 8'h99;
        bad_valid = 0; bad_data = 0; bad_pk = 0; bad_in = 0;
        repeat (20) begin
            @(negedge clock_sig);
            if (resp_valid !== 1'b1)    bad_valid++;
            if (resp_data  !== 8'hC3)   bad_data++;
            if (pk_ready   !== 1'b0)    bad_pk++;
            if (in_ready   !== 1'b0)    bad_in++;
        end
        check_output("bp_resp_valid_bad", bad_valid, 0);
        check_output("bp_resp_data_bad", bad_data, 0);
        check_output("bp_pk_ready_bad", bad_pk, 0);
        check_output("bp_in_ready_bad", bad_in, 0);
        check_output("bp_no_abort", abort_count, 0);
        @(posedge clock_sig);
        #1;
        pk_valid = 1'b0;
        resp_q.push_back(8'hC3); resp_q.push_back(8'h5A);
        resp_ready = 1'b1;
        wait_resp_drain("bp_resp_drain");
        check_output("bp_conf_out", conf_out, 16'h0009);

        // Timeout mid-command: abort 16 idle cycles after the last accepted byte
        apply_stimulus(8'h3A); apply_stimulus(8'h11);
        n = 0;
        do begin
            @(negedge clock_sig);
            n++;
        end while (!abort && n < 40);
        check_output("to_abort_cycle", n, 18);
        @(negedge clock_sig);
        check_output("to_abort_width", abort, 0);
        check_output("to_abort_count", abort_count, 1);
        check_output("to_conf_out", conf_out, 16'h0009);
        check_output("to_updates", upd_count, 4);
        out_q.push_back(8'h41);
        apply_stimulus(8'h41);
        @(negedge clock_sig);
        check_output("to_forwarded", out_q.size(), 0);

        // Asynchronous reset after the first payload byte
        apply_stimulus(8'h3A); apply_stimulus(8'h77);
        resp_ready = 1'b0;
        pk_valid = 1'b1; pk_data = 8'h66;
        #2;
        reset_sig = 1'b1;
        #1;
        check_output("rst_conf_out", conf_out, 16'h0039);
        check_output("rst_resp_valid", resp_valid, 1);
        check_output("rst_resp_data", resp_data, 8'h66);
        pk_valid = 1'b0;
        #1;
        check_output("rst_resp_follow", resp_valid, 0);
        @(posedge clock_sig);
        #1;
        reset_sig = 1'b0;
        resp_ready = 1'b1;
        out_q.push_back(8'h41);
        apply_stimulus(8'h41);
        @(negedge clock_sig);
        check_output("rst_idle_forward", out_q.size(), 0);
        check_output("rst_updates", upd_count, 4);
        check_output("final_resp_q", resp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
